// File: rtl/cpu_pkg.sv
// cpu_pkg: shared memory-access types and constants for the CPU data path
//   mem_size_t   : access size encoding (byte/half/word/double)
//   dmem_state_t : dmem_ctrl FSM states
//   WORD_DEF     : default data width
package cpu_pkg;
  localparam int WORD_DEF = 32;
  typedef enum logic [1:0] {MEM_B, MEM_H, MEM_W, MEM_D} mem_size_t;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} dmem_state_t;
endpackage

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x WORD data RAM, per-byte write enable, synchronous read
//   clk     : clock
//   i_re    : capture i_addr entry into o_rdata
//   i_be    : byte-lane write enables
//   i_addr  : entry index (shared by read and write)
//   i_wdata : lane-aligned write data
//   o_rdata : registered read data, held while i_re is low
module dmem_array #(
  parameter int WORD  = 32,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     i_re,
  input  logic [WORD/8-1:0]        i_be,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [WORD-1:0]          i_wdata,
  output logic [WORD-1:0]          o_rdata
);
  logic [WORD-1:0] r_mem [DEPTH];
  always_ff @(posedge clk) begin
    for (int b = 0; b < WORD/8; b++)
      if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    if (i_re) o_rdata <= r_mem[i_addr];
  end
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: valid/ready data-memory controller with lane masking, sign/zero extension and LAT-cycle response
//   clk, rst                  : clock, synchronous active-high reset
//   req_valid/req_ready       : request handshake
//   req_we, req_addr          : store flag, byte address
//   req_size, req_unsigned    : access size, zero-extend loads
//   req_wdata                 : right-aligned store data
//   resp_valid/resp_ready     : response handshake
//   resp_rdata, resp_err      : extended load data (0 for stores), misalignment flag
// Optional: DMEM_MISALIGN_TRAP_EN flags misaligned accesses instead of aligning them down.
module dmem_ctrl import cpu_pkg::*; #(
  parameter int WORD  = WORD_DEF,
  parameter int DEPTH = 1024,
  parameter int LAT   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [WORD-1:0] req_addr,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [WORD-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [WORD-1:0] resp_rdata,
  output logic            resp_err
);
  localparam int NB = WORD/8;
  localparam int OB = $clog2(NB);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(WORD) + 1;
  localparam logic [1:0] CNT_END = 2'(LAT - 2);
  dmem_state_t r_state;
  logic [1:0] r_cnt;
  logic r_ready, r_valid, r_we, r_uns, r_err;
  mem_size_t r_size;
  logic [OB-1:0] r_off;
  mem_size_t w_size;
  logic [OB-1:0] w_lmask, w_off;
  logic w_acc, w_err;
  logic [NB-1:0] w_be;
  logic [WORD-1:0] w_q, w_sh, w_up, w_ext;
  logic signed [WORD-1:0] w_sext;
  logic [SW-1:0] w_pad;
  assign w_acc  = r_ready & req_valid;
  assign w_size = (WORD == 32 && req_size == MEM_D) ? MEM_W : mem_size_t'(req_size);
  assign w_lmask = OB'((1 << w_size) - 1);
  assign w_off  = req_addr[OB-1:0] & ~w_lmask;
`ifdef DMEM_MISALIGN_TRAP_EN
  assign w_err = |(req_addr[OB-1:0] & w_lmask);
`else
  assign w_err = 1'b0;
`endif
  assign w_be = (w_acc && req_we && !w_err) ? NB'((1 << (1 << w_size)) - 1) << w_off : '0;
  dmem_array #(.WORD(WORD), .DEPTH(DEPTH)) u_array (
    .clk     (clk),
    .i_re    (w_acc & ~req_we),
    .i_be    (w_be),
    .i_addr  (AW'(req_addr >> OB)),
    .i_wdata (req_wdata << {w_off, 3'b000}),
    .o_rdata (w_q)
  );
  // Push the selected lanes to the top of the word, then shift back down so
  // the arithmetic shift replicates the access's sign bit.
  assign w_pad  = SW'(WORD - (8 << r_size));
  assign w_sh   = w_q >> {r_off, 3'b000};
  assign w_up   = w_sh << w_pad;
  assign w_sext = $signed(w_up) >>> w_pad;
  assign w_ext  = r_uns ? w_up >> w_pad : w_sext;
  assign req_ready  = r_ready;
  assign resp_valid = r_valid;
  assign resp_err   = r_valid & r_err;
  assign resp_rdata = (r_valid && !r_we && !r_err) ? w_ext : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_err   <= 1'b0;
      r_size  <= MEM_B;
      r_off   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready <= ~w_acc;
          if (w_acc) begin
            r_we    <= req_we;
            r_uns   <= req_unsigned;
            r_size  <= w_size;
            r_off   <= w_off;
            r_err   <= w_err;
            r_cnt   <= '0;
            r_state <= (LAT == 1) ? S_RESP : S_WAIT;
            r_valid <= (LAT == 1);
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == CNT_END) begin
            r_state <= S_RESP;
            r_valid <= 1'b1;
            r_cnt   <= '0;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_state <= S_IDLE;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: table-driven scoreboard bench for dmem_ctrl (WORD=32, LAT=3)
module tb_dmem_ctrl;
  localparam int LAT = 3;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, resp_ready = 1'b1;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0] req_size = '0;
  logic req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  dmem_ctrl #(.WORD(32), .DEPTH(1024), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic we; logic [31:0] addr; logic [1:0] sz; logic uns;
    logic [31:0] wd; logic [31:0] er; logic ee;
  } vec_t;
  typedef struct {logic [31:0] rd; logic ee; int id;} exp_t;
  exp_t sb[$];
  vec_t tv[24];
  int errors = 0, checks = 0;
  int n;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic we, input logic [31:0] a, input logic [1:0] sz,
                              input logic u, input logic [31:0] wd, input logic [31:0] er, input logic ee);
    vec_t v;
    v.we = we; v.addr = a; v.sz = sz; v.uns = u; v.wd = wd; v.er = er; v.ee = ee;
    return v;
  endfunction
  always @(negedge clk) begin
    if (resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got rdata %0h with empty scoreboard", resp_rdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("rdata[%0d]", e.id), resp_rdata, e.rd);
        chk($sformatf("err[%0d]", e.id), resp_err, e.ee);
      end
    end
  end
  task automatic drive(input vec_t v);
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr;
    req_size = v.sz; req_unsigned = v.uns; req_wdata = v.wd;
  endtask
  task automatic xfer(input vec_t v, input int id);
    int k;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("req_ready[%0d]", id), req_ready, 1);
    drive(v);
    sb.push_back('{rd: v.er, ee: v.ee, id: id});
    @(posedge clk);
    #1 req_valid = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!resp_valid && k < 20);
    chk($sformatf("latency[%0d]", id), k, LAT);
    @(posedge clk);
  endtask
  initial begin
    tv[0]  = mk(1, 32'h10,   2, 0, 32'hDEADBEEF, 32'h0,        0);
    tv[1]  = mk(0, 32'h10,   2, 0, 32'h0,        32'hDEADBEEF, 0);
    tv[2]  = mk(1, 32'h13,   0, 0, 32'h12345680, 32'h0,        0);
    tv[3]  = mk(0, 32'h13,   0, 0, 32'h0,        32'hFFFFFF80, 0);
    tv[4]  = mk(0, 32'h13,   0, 1, 32'h0,        32'h00000080, 0);
    tv[5]  = mk(0, 32'h10,   2, 0, 32'h0,        32'h80ADBEEF, 0);
    tv[6]  = mk(1, 32'h20,   2, 0, 32'hA5A5A5A5, 32'h0,        0);
    tv[7]  = mk(1, 32'h22,   1, 0, 32'hFFFF1234, 32'h0,        0);
    tv[8]  = mk(0, 32'h22,   1, 0, 32'h0,        32'h00001234, 0);
    tv[9]  = mk(0, 32'h20,   1, 1, 32'h0,        32'h0000A5A5, 0);
    tv[10] = mk(0, 32'h20,   2, 0, 32'h0,        32'h1234A5A5, 0);
    tv[11] = mk(0, 32'h20,   1, 0, 32'h0,        32'hFFFFA5A5, 0);
    tv[12] = mk(1, 32'h30,   2, 0, 32'h80007F01, 32'h0,        0);
    tv[13] = mk(0, 32'h31,   0, 0, 32'h0,        32'h0000007F, 0);
    tv[14] = mk(0, 32'h33,   0, 0, 32'h0,        32'hFFFFFF80, 0);
    tv[15] = mk(0, 32'h32,   1, 0, 32'h0,        32'hFFFF8000, 0);
    tv[16] = mk(0, 32'h32,   1, 1, 32'h0,        32'h00008000, 0);
    tv[17] = mk(0, 32'h1010, 2, 0, 32'h0,        32'h80ADBEEF, 0);
    tv[18] = mk(0, 32'h10,   3, 0, 32'h0,        32'h80ADBEEF, 0);
    tv[19] = mk(0, 32'h30,   0, 1, 32'h0,        32'h00000001, 0);
`ifdef DMEM_MISALIGN_TRAP_EN
    tv[20] = mk(1, 32'h11,   2, 0, 32'hCAFEF00D, 32'h0,        1);
    tv[21] = mk(0, 32'h10,   2, 0, 32'h0,        32'h80ADBEEF, 0);
    tv[22] = mk(0, 32'h21,   1, 0, 32'h0,        32'h0,        1);
    tv[23] = mk(0, 32'h12,   0, 0, 32'h0,        32'hFFFFFFAD, 0);
`else
    tv[20] = mk(1, 32'h11,   2, 0, 32'hCAFEF00D, 32'h0,        0);
    tv[21] = mk(0, 32'h10,   2, 0, 32'h0,        32'hCAFEF00D, 0);
    tv[22] = mk(0, 32'h21,   1, 0, 32'h0,        32'hFFFFA5A5, 0);
    tv[23] = mk(0, 32'h12,   0, 0, 32'h0,        32'hFFFFFFFE, 0);
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_err", resp_err, 0);
    rst = 1'b0;
    @(posedge clk);
    #1 chk("post_rst_req_ready", req_ready, 1);
    for (int i = 0; i < 24; i++) xfer(tv[i], i);
    @(negedge clk);
    resp_ready = 1'b0;
    drive(mk(0, 32'h20, 2, 0, 32'h0, 32'h0, 0));
    sb.push_back('{rd: 32'h1234A5A5, ee: 1'b0, id: 100});
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 20);
    chk("stall_latency", n, LAT);
    repeat (5) begin
      chk("stall_resp_valid", resp_valid, 1);
      chk("stall_resp_rdata", resp_rdata, 32'h1234A5A5);
      chk("stall_req_ready", req_ready, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("stall_done_req_ready", req_ready, 1);
    chk("stall_done_resp_valid", resp_valid, 0);
    drive(mk(1, 32'h40, 2, 0, 32'h11223344, 32'h0, 0));
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("wait_req_ready", req_ready, 0);
    chk("wait_resp_valid", resp_valid, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_req_ready", req_ready, 0);
    chk("midrst_resp_valid", resp_valid, 0);
    rst = 1'b0;
    @(posedge clk);
    #1 chk("after_midrst_req_ready", req_ready, 1);
    repeat (6) begin
      @(negedge clk);
      chk("dropped_resp_valid", resp_valid, 0);
    end
    xfer(mk(0, 32'h40, 2, 0, 32'h0, 32'h11223344, 0), 101);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
